// File: rtl/comparador_sequencia_pkg.sv
// Shared types and constants for the sequential move comparator.
package comparador_pkg;

  localparam int WIDTH_PAD = 4;
  localparam int DEPTH_PAD = 16;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ESPERA     = 2'd1,
    FIM_ACERTO = 2'd2,
    FIM_ERRO   = 2'd3
  } estado_e;

  // Address width for a sequence memory of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/comparador_sequencia_if.sv
// Move/result bus between the button capture, sequence memory and game FSM.
interface comparador_sequencia_if
  import comparador_pkg::*;
#(
  parameter int WIDTH = WIDTH_PAD,
  parameter int DEPTH = DEPTH_PAD
);
  localparam int AW = addr_w(DEPTH);

  logic             iniciar;
  logic [AW:0]      tamanho;
  logic             jogada_valida;
  logic [WIDTH-1:0] jogada;
  logic [WIDTH-1:0] esperado;
  logic [AW-1:0]    endereco;
  logic             igual;
  logic             diferente;
  logic             fim_sequencia;
  logic [AW:0]      acertos;
  logic             ocupado;
  logic             estourou;

  // Game side: starts rounds, presents moves and the memory word.
  modport master (
    output iniciar, tamanho, jogada_valida, jogada, esperado,
    input  endereco, igual, diferente, fim_sequencia, acertos, ocupado, estourou
  );

  // Comparator side.
  modport slave (
    input  iniciar, tamanho, jogada_valida, jogada, esperado,
    output endereco, igual, diferente, fim_sequencia, acertos, ocupado, estourou
  );

endinterface

// File: rtl/comparador_sequencia_contador_timeout.sv
// Idle-cycle counter for the per-move timeout; holds at its terminal count.
module contador_timeout #(
  parameter int LIMITE = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  output logic terminal
);
  localparam int CW = (LIMITE <= 1) ? 1 : $clog2(LIMITE);

  logic [CW-1:0] cnt_q, cnt_d;

  assign terminal = (cnt_q == CW'(LIMITE - 1));

  // Clear wins; otherwise count up until terminal and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (limpa)                      cnt_d = '0;
    else if (habilita && !terminal) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/comparador_sequencia.sv
// Sequential move comparator: walks the expected sequence and compares each
// validated move against the memory word at the current address.
// Optional per-move timeout: define COMPARADOR_SEQUENCIA_TIMEOUT_EN.
module comparador_sequencia
  import comparador_pkg::*;
#(
  parameter int WIDTH       = WIDTH_PAD,
  parameter int DEPTH       = DEPTH_PAD,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  comparador_sequencia_if.slave bus
);
  localparam int          AW      = addr_w(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  estado_e       state_q, state_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW:0]   ac_q, ac_d;
  logic [AW:0]   lim_q, lim_d;
  logic          igual_q, igual_d;
  logic          dif_q, dif_d;
  logic          fim_q, fim_d;
  logic          est_q, est_d;
  logic          ocup_q, ocup_d;
  logic          ultimo;
  logic          tmo_fim;

`ifdef COMPARADOR_SEQUENCIA_TIMEOUT_EN
  logic tmo_limpa;
  logic tmo_hab;

  // Count idle cycles only while waiting; any move or round start restarts it.
  assign tmo_limpa = bus.iniciar | bus.jogada_valida | (state_q != ESPERA);
  assign tmo_hab   = (state_q == ESPERA);

  contador_timeout #(.LIMITE(TIMEOUT_CYC)) u_tmo (
    .clock    (clock),
    .reset    (reset),
    .limpa    (tmo_limpa),
    .habilita (tmo_hab),
    .terminal (tmo_fim)
  );
`else
  assign tmo_fim = 1'b0;
`endif

  // Current entry is the last one of the round (limite >= 1 whenever in ESPERA).
  assign ultimo = ({1'b0, end_q} == (lim_q - 1'b1));

  // Next-state and next-output logic; iniciar overrides everything else.
  always_comb begin
    state_d = state_q;
    end_d   = end_q;
    ac_d    = ac_q;
    lim_d   = lim_q;
    igual_d = 1'b0;
    dif_d   = 1'b0;
    fim_d   = 1'b0;
    est_d   = 1'b0;
    if (bus.iniciar) begin
      end_d = '0;
      ac_d  = '0;
      lim_d = (bus.tamanho > DEPTH_L) ? DEPTH_L : bus.tamanho;
      if (bus.tamanho == '0) begin
        state_d = FIM_ACERTO;
        fim_d   = 1'b1;
      end else begin
        state_d = ESPERA;
      end
    end else if (state_q == ESPERA) begin
      if (bus.jogada_valida) begin
        if (bus.jogada == bus.esperado) begin
          igual_d = 1'b1;
          ac_d    = ac_q + 1'b1;
          if (ultimo) begin
            fim_d   = 1'b1;
            state_d = FIM_ACERTO;
          end else begin
            end_d = end_q + 1'b1;
          end
        end else begin
          dif_d   = 1'b1;
          state_d = FIM_ERRO;
        end
      end else if (tmo_fim) begin
        est_d   = 1'b1;
        dif_d   = 1'b1;
        state_d = FIM_ERRO;
      end
    end
    ocup_d = (state_d == ESPERA);
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= OCIOSO;
      end_q   <= '0;
      ac_q    <= '0;
      lim_q   <= '0;
      igual_q <= 1'b0;
      dif_q   <= 1'b0;
      fim_q   <= 1'b0;
      est_q   <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
      ac_q    <= ac_d;
      lim_q   <= lim_d;
      igual_q <= igual_d;
      dif_q   <= dif_d;
      fim_q   <= fim_d;
      est_q   <= est_d;
      ocup_q  <= ocup_d;
    end
  end

  assign bus.endereco      = end_q;
  assign bus.acertos       = ac_q;
  assign bus.igual         = igual_q;
  assign bus.diferente     = dif_q;
  assign bus.fim_sequencia = fim_q;
  assign bus.estourou      = est_q;
  assign bus.ocupado       = ocup_q;

endmodule

// File: tb/tb_comparador_sequencia.sv
// Bench for comparador_sequencia: directed table, corner sequences and
// random rounds checked against a queue-based round model.
module tb_comparador_sequencia;
  import comparador_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  localparam int AW    = addr_w(DEPTH);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  comparador_sequencia_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  comparador_sequencia #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  assign bus.esperado = mem[bus.endereco];

  int n_tests = 0;
  int n_fail  = 0;

  // Round model: pending expected words in a queue, hits counted.
  int m_phase = 0;  // 0 idle, 1 waiting, 2 done ok, 3 done error
  int m_hits  = 0;
  int m_len   = 0;
  int m_idle  = 0;
  int pend[$];
  bit e_ig, e_df, e_fim, e_est;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  function automatic int m_addr();
    if (m_phase == 2 && m_len > 0) return m_len - 1;
    return m_hits;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hits = 0; m_len = 0; m_idle = 0; pend.delete();
    e_ig = 0; e_df = 0; e_fim = 0; e_est = 0;
  endtask

  task automatic model_step();
    e_ig = 0; e_df = 0; e_fim = 0; e_est = 0;
    if (bus.iniciar) begin
      m_len  = (int'(bus.tamanho) > DEPTH) ? DEPTH : int'(bus.tamanho);
      m_hits = 0;
      m_idle = 0;
      pend.delete();
      for (int k = 0; k < m_len; k++) pend.push_back(int'(mem[k]));
      if (m_len == 0) begin m_phase = 2; e_fim = 1; end
      else m_phase = 1;
    end else if (m_phase == 1) begin
      if (bus.jogada_valida) begin
        m_idle = 0;
        if (int'(bus.jogada) == pend[0]) begin
          void'(pend.pop_front());
          m_hits++;
          e_ig = 1;
          if (pend.size() == 0) begin m_phase = 2; e_fim = 1; end
        end else begin
          e_df = 1; m_phase = 3;
        end
      end
`ifdef COMPARADOR_SEQUENCIA_TIMEOUT_EN
      else if (m_idle == TMO - 1) begin
        e_est = 1; e_df = 1; m_phase = 3;
      end else begin
        m_idle++;
      end
`endif
    end
  endtask

  task automatic check_model();
    chk("igual",         bus.igual,         e_ig);
    chk("diferente",     bus.diferente,     e_df);
    chk("fim_sequencia", bus.fim_sequencia, e_fim);
    chk("estourou",      bus.estourou,      e_est);
    chk("endereco",      bus.endereco,      m_addr());
    chk("acertos",       bus.acertos,       m_hits);
    chk("ocupado",       bus.ocupado,       m_phase == 1);
  endtask

  task automatic drv(input bit ini, input int tam, input bit jv, input int jog);
    bus.iniciar       = ini;
    bus.tamanho       = tam[AW:0];
    bus.jogada_valida = jv;
    bus.jogada        = jog[WIDTH-1:0];
  endtask

  // One clock: model consumes the applied inputs, outputs checked at negedge.
  task automatic step();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_model();
  endtask

  task automatic load_mem(input bit sel);
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    if (!sel) begin
      mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
    end else begin
      mem[0] = 4'b1000; mem[1] = 4'b0001; mem[2] = 4'b0010; mem[3] = 4'b0100;
    end
  endtask

  typedef struct {
    bit ms; bit ini; int tam; bit jv; int jog;
    bit ig; bit df; bit fim; int ende; int ac; bit oc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    //          ms ini tam jv jog  ig df fim end ac oc
    tbl[0]  = '{0, 1,  3,  0, 0,   0, 0, 0,  0,  0, 1};
    tbl[1]  = '{0, 0,  0,  1, 1,   1, 0, 0,  1,  1, 1};
    tbl[2]  = '{0, 0,  0,  1, 2,   1, 0, 0,  2,  2, 1};
    tbl[3]  = '{0, 0,  0,  1, 4,   1, 0, 1,  2,  3, 0};
    tbl[4]  = '{0, 0,  0,  0, 0,   0, 0, 0,  2,  3, 0};
    tbl[5]  = '{0, 0,  0,  1, 4,   0, 0, 0,  2,  3, 0};
    tbl[6]  = '{1, 1,  4,  0, 0,   0, 0, 0,  0,  0, 1};
    tbl[7]  = '{1, 0,  0,  1, 8,   1, 0, 0,  1,  1, 1};
    tbl[8]  = '{1, 0,  0,  1, 2,   0, 1, 0,  1,  1, 0};
    tbl[9]  = '{1, 0,  0,  1, 1,   0, 0, 0,  1,  1, 0};
    tbl[10] = '{1, 1,  4,  0, 0,   0, 0, 0,  0,  0, 1};
    tbl[11] = '{1, 0,  0,  1, 8,   1, 0, 0,  1,  1, 1};
    tbl[12] = '{1, 1,  4,  1, 1,   0, 0, 0,  0,  0, 1};
    tbl[13] = '{1, 0,  0,  1, 8,   1, 0, 0,  1,  1, 1};
    tbl[14] = '{1, 1,  0,  0, 0,   0, 0, 1,  0,  0, 0};
    tbl[15] = '{1, 0,  0,  0, 0,   0, 0, 0,  0,  0, 0};

    model_reset();
    load_mem(0);
    drv(0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    check_model();
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      load_mem(tbl[i].ms);
      drv(tbl[i].ini, tbl[i].tam, tbl[i].jv, tbl[i].jog);
      step();
      chk($sformatf("tbl%0d.igual", i),     bus.igual,         tbl[i].ig);
      chk($sformatf("tbl%0d.diferente", i), bus.diferente,     tbl[i].df);
      chk($sformatf("tbl%0d.fim", i),       bus.fim_sequencia, tbl[i].fim);
      chk($sformatf("tbl%0d.endereco", i),  bus.endereco,      tbl[i].ende);
      chk($sformatf("tbl%0d.acertos", i),   bus.acertos,       tbl[i].ac);
      chk($sformatf("tbl%0d.ocupado", i),   bus.ocupado,       tbl[i].oc);
    end

    // Full-depth rounds, including a length clamped to DEPTH.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'($urandom);
      drv(1, (r == 0) ? 16 : 31, 0, 0);
      step();
      for (int k = 0; k < DEPTH; k++) begin
        drv(0, 0, 1, int'(mem[k]));
        step();
      end
      chk("full.fim",      bus.fim_sequencia, 1);
      chk("full.endereco", bus.endereco,      15);
      chk("full.acertos",  bus.acertos,       16);
      drv(0, 0, 0, 0);
      step();
      chk("full.hold_end", bus.endereco, 15);
      chk("full.ocupado",  bus.ocupado,  0);
    end

    // Asynchronous reset while waiting at address 5.
    for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'($urandom);
    drv(1, 10, 0, 0);
    step();
    for (int k = 0; k < 5; k++) begin
      drv(0, 0, 1, int'(mem[k]));
      step();
    end
    chk("pre_rst.endereco", bus.endereco, 5);
    drv(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst.endereco", bus.endereco, 0);
    chk("rst.acertos",  bus.acertos,  0);
    chk("rst.ocupado",  bus.ocupado,  0);
    chk("rst.pulses",   {bus.igual, bus.diferente, bus.fim_sequencia, bus.estourou}, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step();

`ifdef COMPARADOR_SEQUENCIA_TIMEOUT_EN
    // No move for TMO cycles -> timeout; move in the terminal cycle wins.
    load_mem(1);
    drv(1, 4, 0, 0);
    step();
    drv(0, 0, 0, 0);
    for (int k = 0; k < TMO; k++) step();
    chk("tmo.estourou",  bus.estourou,  1);
    chk("tmo.diferente", bus.diferente, 1);
    chk("tmo.ocupado",   bus.ocupado,   0);
    drv(1, 4, 0, 0);
    step();
    drv(0, 0, 0, 0);
    for (int k = 0; k < TMO - 1; k++) step();
    drv(0, 0, 1, 8);
    step();
    chk("tmo_win.igual",    bus.igual,    1);
    chk("tmo_win.estourou", bus.estourou, 0);
    drv(0, 0, 0, 0);
    for (int k = 0; k < TMO; k++) step();
    chk("tmo2.estourou", bus.estourou, 1);
`endif

    // Random rounds.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) begin
        for (int k = 0; k < DEPTH; k++) mem[k] = WIDTH'($urandom);
        drv(1, $urandom_range(31), $urandom_range(1), $urandom_range(15));
      end else begin
        int j;
        j = (pend.size() > 0 && $urandom_range(3) != 0) ? pend[0] : $urandom_range(15);
        drv(0, $urandom_range(31), $urandom_range(1), j);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comparador_sequencia.md
Name: comparador_sequencia

Overview:
- Sequential, parametrised move comparator for the memory-game datapath.
- Steps through an expected move sequence held in an external memory and compares each validated player move with the entry at the current address.
- Registers equal/different results, counts hits and flags end of sequence.
- Sits between the button-capture logic and the game-control FSM; replaces the single-shot combinational move comparison.

Parameters:
WIDTH, 4, width of one move / memory word
DEPTH, 16, maximum sequence length (power of 2, >=2)
TIMEOUT_CYC, 1000, idle cycles allowed per move (used only with the optional feature)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start-round strobe; loads tamanho
tamanho  in  clog2(DEPTH)+1  sequence length for this round
jogada_valida  in  1  one-cycle strobe: jogada is valid
jogada  in  WIDTH  player move
esperado  in  WIDTH  memory word at endereco (combinational read, same cycle)
endereco  out  clog2(DEPTH)  current sequence address
igual  out  1  one-cycle pulse: move matched
diferente  out  1  one-cycle pulse: move mismatched (or timeout)
fim_sequencia  out  1  one-cycle pulse: last entry matched
acertos  out  clog2(DEPTH)+1  matched moves this round
ocupado  out  1  high while waiting for moves
estourou  out  1  one-cycle pulse: move timeout

Behaviour:
- Reset (async, active-high): state OCIOSO; endereco=0, acertos=0, limite=0; igual, diferente, fim_sequencia, estourou, ocupado all 0.
- Mid-operation reset: returns to these values immediately, without waiting for a clock edge.
- States: OCIOSO, ESPERA, FIM_ACERTO, FIM_ERRO. ocupado=1 only in ESPERA. All outputs are registered.
- iniciar, any state, highest priority:
  - endereco<=0, acertos<=0, limite<=min(tamanho, DEPTH).
  - Next state ESPERA. If tamanho==0: next state FIM_ACERTO and fim_sequencia pulses.
  - A jogada_valida in the same cycle is ignored.
- ESPERA with jogada_valida, comparing jogada against esperado; result visible one cycle later (latency 1):
  - Match: igual=1 and acertos+1. If endereco==limite-1: fim_sequencia=1 and state FIM_ACERTO, endereco holds. Otherwise endereco+1 and state stays ESPERA.
  - Mismatch: diferente=1 and state FIM_ERRO. endereco holds, pointing at the failing entry; acertos holds.
- jogada_valida is ignored in OCIOSO, FIM_ACERTO and FIM_ERRO; no pulses are produced.
- FIM_ACERTO and FIM_ERRO hold endereco and acertos until iniciar.
- Width rules:
  - endereco never wraps: with limite==DEPTH the last address is DEPTH-1 and the round terminates there.
  - acertos saturates by construction at DEPTH.
- Pulses are exactly one cycle wide; back-to-back jogada_valida on consecutive cycles is legal and produces one result per cycle.

Optional Feature:
- Macro: COMPARADOR_SEQUENCIA_TIMEOUT_EN.
- Defined:
  - A counter runs in ESPERA; it clears on iniciar, on any jogada_valida, and on leaving ESPERA.
  - When the counter reaches TIMEOUT_CYC-1 with no jogada_valida, the next cycle pulses estourou=1 and diferente=1 and enters FIM_ERRO.
  - If jogada_valida arrives in that same terminal cycle, the move wins and no timeout occurs.
- Undefined: estourou is tied 0, no counter is synthesised, and TIMEOUT_CYC is unused.

Decomposition:
- Package comparador_pkg:
  - State encoding constants (OCIOSO=2'd0, ESPERA=2'd1, FIM_ACERTO=2'd2, FIM_ERRO=2'd3).
  - Default WIDTH/DEPTH constants.
  - An address-width function (clog2).
- One sub-module: contador_timeout (clear, enable, terminal-count output), instantiated only under the macro.

Test Plan:
- Reset then iniciar with tamanho=3, memory {0001,0010,0100}; jogadas 0001,0010,0100 -> igual on each, endereco 0→1→2, fim_sequencia once, acertos=3, state FIM_ACERTO, ocupado=0.
- tamanho=4, memory {1000,0001,0010,0100}; jogadas 1000, then 0010 (expected 0001) -> igual, then diferente; endereco=1, acertos=1, FIM_ERRO; a further jogada_valida produces no pulse.
- tamanho=16 with all moves correct -> endereco reaches 15 and never wraps to 0; fim_sequencia on the 16th move; acertos=16.
- iniciar and jogada_valida in the same cycle mid-round -> move ignored, endereco=0, acertos=0. Also: tamanho=0 -> immediate fim_sequencia, FIM_ACERTO.
- Assert reset between clock edges in ESPERA at endereco=5 -> all outputs zero immediately, state OCIOSO.
- With COMPARADOR_SEQUENCIA_TIMEOUT_EN and TIMEOUT_CYC=8: no move for 8 cycles -> estourou and diferente pulse, FIM_ERRO. A move in cycle 8 -> normal comparison, no timeout.
